// File: rtl/hazard_pkg.sv
// Shared types and bit positions for the MIPS hazard unit and its
// multiply/divide scoreboard.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    // Bit positions inside hazard_singles = {MemtoRegE, RegWriteE, MemtoRegM, RegWriteM, RegWriteW}.
    localparam int S_MEMTOREG_E = 4;
    localparam int S_REGWRITE_E = 3;
    localparam int S_MEMTOREG_M = 2;
    localparam int S_REGWRITE_M = 1;
    localparam int S_REGWRITE_W = 0;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Bundle between the pipeline datapath (master) and the hazard unit (slave):
// packed hazard buses in, stall/flush/forward controls and MD status out.
interface hazard_unit_mc_if #(
    parameter int REG_W = 5
);
    logic [4:0]         hazard_singles;
    logic [7*REG_W-1:0] hazard_mults;
    logic               BranchD;
    logic               MdOpD;
    logic               MfhiloD;
    logic               MdStartE;
    logic               MdIsDivE;

    logic               StallF;
    logic               StallD;
    logic               FlushE;
    logic               ForwardAD;
    logic               ForwardBD;
    logic [1:0]         ForwardAE;
    logic [1:0]         ForwardBE;
    logic               MdBusy;
    logic               MdDone;
    logic               MdErr;

    modport master (
        output hazard_singles, hazard_mults, BranchD, MdOpD, MfhiloD, MdStartE, MdIsDivE,
        input  StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
               MdBusy, MdDone, MdErr
    );

    modport slave (
        input  hazard_singles, hazard_mults, BranchD, MdOpD, MfhiloD, MdStartE, MdIsDivE,
        output StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
               MdBusy, MdDone, MdErr
    );

endinterface

// File: rtl/hazard_unit_mc_md_scoreboard.sv
// Multiply/divide scoreboard: tracks the busy window of the multi-cycle MD
// unit and flags an MD start that arrives while the unit is still busy.
module md_scoreboard
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_is_div,
    output logic o_busy,
    output logic o_done,
    output logic o_err
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    md_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic [CNT_W-1:0] w_load;
    assign w_load = i_is_div ? DIV_LOAD : MUL_LOAD;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_cnt   <= w_load;
                        r_busy  <= 1'b1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    // A start here collides with the running op: it is dropped, not queued.
                    if (i_start) r_err <= 1'b1;
                    if (r_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_cnt   <= w_load;
                        r_busy  <= 1'b1;
                        r_state <= BUSY;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_err  = r_err;

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard detection and forwarding for the 5-stage MIPS pipeline, extended
// with stalls that keep MD-dependent instructions in Decode until MD finishes.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic             clk,
    input  logic             reset,
    hazard_unit_mc_if.slave  hz
);

    logic             w_memtoreg_e, w_regwrite_e, w_memtoreg_m, w_regwrite_m, w_regwrite_w;
    logic [REG_W-1:0] w_rs_d, w_rt_d, w_rs_e, w_rt_e, w_wr_e, w_wr_m, w_wr_w;

    assign w_memtoreg_e = hz.hazard_singles[S_MEMTOREG_E];
    assign w_regwrite_e = hz.hazard_singles[S_REGWRITE_E];
    assign w_memtoreg_m = hz.hazard_singles[S_MEMTOREG_M];
    assign w_regwrite_m = hz.hazard_singles[S_REGWRITE_M];
    assign w_regwrite_w = hz.hazard_singles[S_REGWRITE_W];

    assign w_rs_d = hz.hazard_mults[7*REG_W-1 -: REG_W];
    assign w_rt_d = hz.hazard_mults[6*REG_W-1 -: REG_W];
    assign w_rs_e = hz.hazard_mults[5*REG_W-1 -: REG_W];
    assign w_rt_e = hz.hazard_mults[4*REG_W-1 -: REG_W];
    assign w_wr_e = hz.hazard_mults[3*REG_W-1 -: REG_W];
    assign w_wr_m = hz.hazard_mults[2*REG_W-1 -: REG_W];
    assign w_wr_w = hz.hazard_mults[REG_W-1:0];

    // Memory stage wins over writeback: it holds the younger value. $0 never forwards.
    function automatic fwd_sel_t fwd_pick(input logic [REG_W-1:0] src);
        if (src != '0 && src == w_wr_m && w_regwrite_m) return FWD_M;
        if (src != '0 && src == w_wr_w && w_regwrite_w) return FWD_W;
        return FWD_RF;
    endfunction

    fwd_sel_t w_fwd_ae, w_fwd_be;
    logic     w_fwd_ad, w_fwd_bd;

    assign w_fwd_ae = fwd_pick(w_rs_e);
    assign w_fwd_be = fwd_pick(w_rt_e);
    assign w_fwd_ad = (w_rs_d != '0) && (w_rs_d == w_wr_m) && w_regwrite_m;
    assign w_fwd_bd = (w_rt_d != '0) && (w_rt_d == w_wr_m) && w_regwrite_m;

    logic w_md_busy, w_md_done, w_md_err;

    md_scoreboard #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .i_start  (hz.MdStartE),
        .i_is_div (hz.MdIsDivE),
        .o_busy   (w_md_busy),
        .o_done   (w_md_done),
        .o_err    (w_md_err)
    );

    logic w_lwstall, w_branchstall, w_mdstall, w_stall;

    assign w_lwstall     = w_memtoreg_e && ((w_rt_e == w_rs_d) || (w_rt_e == w_rt_d));
    assign w_branchstall = hz.BranchD &&
                           ((w_regwrite_e && ((w_wr_e == w_rs_d) || (w_wr_e == w_rt_d))) ||
                            (w_memtoreg_m && ((w_wr_m == w_rs_d) || (w_wr_m == w_rt_d))));
    // A start in Execute counts as busy already: the MD result is not ready next cycle.
    assign w_mdstall     = (hz.MfhiloD || hz.MdOpD) && (w_md_busy || hz.MdStartE);
    assign w_stall       = w_lwstall || w_branchstall || w_mdstall;

    // Reset holds a bubble in Execute and silences every other control.
    assign hz.StallF    = !reset && w_stall;
    assign hz.StallD    = !reset && w_stall;
    assign hz.FlushE    =  reset || w_stall;
    assign hz.ForwardAD = !reset && w_fwd_ad;
    assign hz.ForwardBD = !reset && w_fwd_bd;
    assign hz.ForwardAE = reset ? FWD_RF : w_fwd_ae;
    assign hz.ForwardBE = reset ? FWD_RF : w_fwd_be;
    assign hz.MdBusy    = !reset && w_md_busy;
    assign hz.MdDone    = !reset && w_md_done;
    assign hz.MdErr     = !reset && w_md_err;

endmodule
